// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } pll_state_e;

    // Defaults: 74.25 MHz reference, 10 ms lock timeout.
    localparam int unsigned DefRstPulseCycles   = 16;
    localparam int unsigned DefLockTimeoutCycles = 742500;
    localparam int unsigned DefLockStableCycles = 1024;
    localparam int unsigned DefMaxRetries       = 3;
    localparam int unsigned DefSyncStages       = 2;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous bit, resets to 0.
module sync_ff #(
    parameter int unsigned Depth = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [Depth-1:0] sync_q;

    // Shift the asynchronous input through the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Depth-2:0], d};
        end
    end

    assign q = sync_q[Depth-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock handshake sequencer producing a qualified system reset on refclk.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DefRstPulseCycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
    parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
    parameter int unsigned MAX_RETRIES         = DefMaxRetries,
    parameter int unsigned SYNC_STAGES         = DefSyncStages
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic [7:0] relock_count
);

    localparam int unsigned CntW =
        $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [CntW-1:0]   RstLast     = CntW'(RST_PULSE_CYCLES - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

    pll_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [7:0]        relock_cnt_q, relock_cnt_d;
    logic              pll_rst_q, sys_rst_q, pll_ready_q, pll_fail_q;
    logic              lk;

    sync_ff #(
        .Depth(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (lk)
    );

    // Next-state, shared cycle counter, retry and relock counters.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        relock_cnt_d = relock_cnt_q;

        if (relock_req) begin
            state_d = StPllRst;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == RstLast) begin
                        state_d = StWaitLock;
                    end
                end
                StWaitLock: begin
                    cnt_d = cnt_q + 1'b1;
                    // Lock beats a timeout landing on the same cycle.
                    if (lk) begin
                        state_d = StStable;
                    end else if (cnt_q == TimeoutLast) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d == RetryMax) ? StFail : StPllRst;
                    end
                end
                StStable: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!lk) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    if (!lk) begin
                        state_d = StPllRst;
                        if (relock_cnt_q != 8'hFF) begin
                            relock_cnt_d = relock_cnt_q + 8'd1;
                        end
                    end
                end
                StFail: begin
                end
                default: begin
                    state_d = StPllRst;
                end
            endcase
        end

        // A relock request restarts the pulse even when already in PllRst.
        if (relock_req || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    // State and registered outputs decoded from the next state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            retry_q      <= '0;
            relock_cnt_q <= '0;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            pll_ready_q  <= 1'b0;
            pll_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            relock_cnt_q <= relock_cnt_d;
            pll_rst_q    <= (state_d == StPllRst);
            sys_rst_q    <= (state_d != StRun);
            pll_ready_q  <= (state_d == StRun);
            pll_fail_q   <= (state_d == StFail);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign pll_ready    = pll_ready_q;
    assign pll_fail     = pll_fail_q;
    assign relock_count = relock_cnt_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the reset and lock handshake of the core's fractional PLL (74.25 MHz reference, five output clocks) and produces a single qualified system reset. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing downstream logic. It also handles loss of lock at runtime and software-requested relock. It runs on the always-present reference clock, not on any PLL output.

## Interface
- `RST_PULSE_CYCLES`, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 742500: cycles to wait for synced lock before retrying (10 ms).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synced-lock cycles required before release (≥1).
- `MAX_RETRIES`, 3: failed lock attempts tolerated before FAIL (≥1).
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked` (≥2).
- `refclk` in 1: the only clock; the 74.25 MHz reference.
- `rst` in 1: reset, asynchronous, active-high.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle request to restart the PLL (e.g. after reconfiguration).
- `pll_rst` out 1: drives the PLL reset.
- `sys_rst` out 1: qualified system reset, active-high, `refclk` domain.
- `pll_ready` out 1: high only in RUN.
- `pll_fail` out 1: high only in FAIL.
- `relock_count` out 8: saturating count of runtime lock losses.

## Operation
- `pll_locked` passes through a `SYNC_STAGES` flop chain. All decisions use the synced value `lk`.
- One shared cycle counter, cleared on every state entry. Width is `$clog2` of the largest cycle parameter, plus 1.
- A retry counter, width `$clog2(MAX_RETRIES+1)`.
- States:
  - PLL_RST: `pll_rst=1`. After `RST_PULSE_CYCLES` cycles, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst=0`.
    - If `lk=1`, go to STABLE.
    - Otherwise, when the counter reaches `LOCK_TIMEOUT_CYCLES-1`, increment the retry count. If it now equals `MAX_RETRIES`, go to FAIL; otherwise go to PLL_RST.
  - STABLE: if `lk=0`, return to WAIT_LOCK; the timeout restarts and the retry count is unchanged. After `LOCK_STABLE_CYCLES` consecutive `lk=1` cycles, go to RUN and clear the retry count.
  - RUN: `sys_rst=0`, `pll_ready=1`. If `lk=0`, increment `relock_count` (saturating at 255) and go to PLL_RST.
  - FAIL: `pll_rst=0`, `sys_rst=1`, `pll_fail=1`. Leaves only on `rst` or `relock_req`.
- `relock_req` has priority over every other transition in every state. It goes to PLL_RST, clears the retry count and does not change `relock_count`.
- All outputs are registered and decoded from the next state.
- `sys_rst=1` in every state except RUN.
- Downstream per-domain reset synchronizers live at each `outclk` consumer, not here.

## Timing
- Reset values: state PLL_RST, counters 0, `pll_rst=1`, `sys_rst=1`, `pll_ready=0`, `pll_fail=0`, `relock_count=0`, synchronizer flops 0.
- Asserting `rst` mid-operation immediately forces the reset values, including `sys_rst=1`.
- After `rst` deasserts, `pll_rst` stays high for exactly `RST_PULSE_CYCLES` rising edges.
- Lock latency: `lk` follows `pll_locked` by `SYNC_STAGES` edges. `sys_rst` falls `SYNC_STAGES+LOCK_STABLE_CYCLES+1` edges after `pll_locked` rises in WAIT_LOCK.
- Loss of lock in RUN: `sys_rst` rises `SYNC_STAGES+1` edges after `pll_locked` falls.
- `relock_req`: `pll_rst` rises on the next edge.
- Simultaneous events:
  - Timeout and `lk` rising on the same cycle: lock wins.
  - `relock_req` and lock loss in RUN on the same cycle: `relock_req` wins; `relock_count` is not incremented.

## Structure
- Shared package `pll_seq_pkg`: state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL) and the default parameter constants.
- One natural sub-module: `sync_ff` (parameterised depth, reset-to-0), used for `pll_locked`.

## Test plan
Parameters for all scenarios: `RST_PULSE_CYCLES=4`, `LOCK_TIMEOUT_CYCLES=32`, `LOCK_STABLE_CYCLES=8`, `MAX_RETRIES=2`, `SYNC_STAGES=2`.

1. Release `rst`; raise `pll_locked` 10 cycles later → `pll_rst` is high for exactly 4 edges; `sys_rst` falls 11 edges after lock; `pll_ready=1`.
2. Glitch `pll_locked` low for 1 cycle during STABLE → stable count restarts; `sys_rst` stays high until 8 further locked cycles.
3. Keep `pll_locked=0` → exactly 2 `pll_rst` pulses, 32 cycles apart plus the pulse length; then `pll_fail=1`, `sys_rst=1`, `pll_rst=0`. Pulse `relock_req` → PLL_RST, `pll_fail=0`.
4. In RUN, drop `pll_locked` for 3 cycles, then restore → `sys_rst=1` after 3 edges; `relock_count=1`; `pll_rst` pulses; release follows the usual stable delay. Repeat 300 times → `relock_count=255`.
5. Pulse `relock_req` in RUN on the same cycle `pll_locked` falls → `relock_count` unchanged; `pll_rst=1` next edge.
6. Assert `rst` asynchronously in STABLE and in RUN → all outputs take reset values before the next edge; sequence restarts cleanly.
